i2c_ahb_txn_arbiter: RTL and testbench
======================================

// Module: i2c_ahb_txn_arbiter
// PURPOSE
//  Shares one I2C-to-AHB bridge engine (word read/write over I2C to slave 0x66) among NREQ requesters.
//  Accepts one transaction at a time (write: addr+data; read: addr), round-robin grant, holds operands
//  stable to the engine, waits for completion or timeout, returns rdata/error to the winning requester.
//  Sits between on-chip requesters (debug, DMA, CPU shim) and the soft I2C AHB master engine.
// PARAMETERS
//  NREQ        2        number of requesters (2..8)
//  TMO_W       20       timeout counter width
//  TMO_CYC     20'hFFFFF cycles in WAIT before declaring timeout (must be >0)
// PORTS
//  clk_i        in   1          clock
//  rst_ni       in   1          async reset, active low
//  req_valid_i  in   NREQ       per-requester transaction request
//  req_ready_o  out  NREQ       one-hot accept; handshake = valid&ready
//  req_we_i     in   NREQ       1=write, 0=read
//  req_addr_i   in   32*NREQ    AHB address, requester k at [32k+:32]
//  req_wdata_i  in   32*NREQ    AHB write data, requester k at [32k+:32]
//  rsp_valid_o  out  NREQ       one-hot, one-cycle completion pulse
//  rsp_rdata_o  out  32         read data, valid with rsp_valid_o
//  rsp_err_o    out  1          1=NACK or timeout, valid with rsp_valid_o
//  eng_start_o  out  1          one-cycle start pulse to engine
//  eng_we_o     out  1          latched direction, stable START..RESP
//  eng_addr_o   out  32         latched address, stable START..RESP
//  eng_wdata_o  out  32         latched write data, stable START..RESP
//  eng_done_i   in   1          one-cycle completion pulse from engine
//  eng_nack_i   in   1          engine saw NACK; sampled with eng_done_i
//  eng_rdata_i  in   32         engine read word; sampled with eng_done_i
//  busy_o       out  1          1 in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr=0, timer=0, latched operands 0.
//  States: IDLE -> START -> WAIT -> RESP -> IDLE.
//  IDLE: winner = first k with req_valid_i[k] searching rr_ptr, rr_ptr+1, .. mod NREQ;
//   req_ready_o = onehot(winner) combinationally, only in IDLE and only if any valid; else 0.
//   On handshake latch we/addr/wdata and id=winner; -> START. No valid: stay.
//  START: eng_start_o=1 for exactly this cycle; timer<=0; -> WAIT.
//  WAIT: timer+1 per cycle, saturating. eng_done_i=1: rdata<=we?0:eng_rdata_i, err<=eng_nack_i; -> RESP.
//   Else timer==TMO_CYC-1: rdata<=0, err<=1; -> RESP. done and timeout same cycle: done wins.
//  RESP: rsp_valid_o[id]=1 one cycle; rsp_rdata_o/rsp_err_o held until next RESP;
//   rr_ptr <= (id==NREQ-1)?0:id+1; -> IDLE. No backpressure on rsp.
//  Latency: handshake->eng_start_o 1 cycle; eng_done_i->rsp_valid_o 1 cycle; min 3 cycles accept->IDLE.
//  eng_done_i outside WAIT is ignored (late done after timeout is discarded, no second rsp).
//  Requester dropping req_valid_i before handshake: no effect, no state change.
//  Reset mid-operation: immediate return to IDLE, no rsp pulse; engine is reset by the same rst_ni.
// STRUCTURE
//  Package i2c_ahb_pkg: state encoding localparams, SLAVE_DEVICE_ADDR=7'h66, bridge reg offsets
//   (WADDR 0x00, RADDR 0x08, RDATA 0x0C), shared with the engine.
//  Sub-module i2c_rr_pick: combinational round-robin picker (req vector, ptr -> onehot, idx, any).
// TESTING
//  Single write req0 addr=0x1000_0004 data=0xDEAD_BEEF, done after 50 cyc -> eng_start 1 pulse,
//   eng_addr/wdata stable, rsp_valid=2'b01, err=0, rdata=0.
//  Single read req1 addr=0x2000_0000, done with rdata=0x1234_5678 -> rsp_valid=2'b10, rdata=0x12345678.
//  Both valid continuously, 4 txns -> grant order 0,1,0,1; never two rsp bits set.
//  No done, TMO_CYC=16 -> rsp_valid 16+1 cycles after START with err=1, rdata=0; late done ignored.
//  eng_nack_i=1 with done on read -> err=1, rdata = sampled eng_rdata_i; rr_ptr advances.
//  rst_ni low during WAIT -> busy_o=0, all outputs 0, next req accepted from requester 0.

Source files
------------

// File: rtl/i2c_ahb_txn_arbiter_pkg.sv
// Shared constants for the I2C-to-AHB bridge engine and its transaction arbiter.
package i2c_ahb_pkg;

   // 7-bit I2C address of the bridge slave
   localparam logic [6:0] SLAVE_DEVICE_ADDR = 7'h66;

   // Bridge register offsets used by the engine
   localparam logic [7:0] REG_WADDR = 8'h00;
   localparam logic [7:0] REG_RADDR = 8'h08;
   localparam logic [7:0] REG_RDATA = 8'h0C;

   // Arbiter state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_START = ST_START,
      S_WAIT  = ST_WAIT,
      S_RESP  = ST_RESP
   } arb_state_e;

endpackage

// File: rtl/i2c_ahb_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module i2c_rr_pick
   import i2c_ahb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  onehot_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int               kk;
   logic [IDX_W-1:0] k_idx;

   // Scan from the farthest candidate back to ptr so the nearest valid wins.
   always_comb begin
      kk       = 0;
      k_idx    = '0;
      idx_o    = '0;
      onehot_o = '0;
      any_o    = |req_i;
      for (int i = NREQ - 1; i >= 0; i--) begin
         kk    = (int'(ptr_i) + i) % NREQ;
         k_idx = kk[IDX_W-1:0];
         if (req_i[k_idx]) idx_o = k_idx;
      end
      onehot_o[idx_o] = any_o;
   end

endmodule

// File: rtl/i2c_ahb_txn_arbiter.sv
// Shares one I2C-to-AHB bridge engine among NREQ requesters, one transaction at a time.
module i2c_ahb_txn_arbiter
   import i2c_ahb_pkg::*;
#(
   parameter int          NREQ    = 2,
   parameter int          TMO_W   = 20,
   parameter int unsigned TMO_CYC = 32'hFFFFF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NREQ-1:0]   req_valid_i,
   output logic [NREQ-1:0]   req_ready_o,
   input  logic [NREQ-1:0]   req_we_i,
   input  logic [32*NREQ-1:0] req_addr_i,
   input  logic [32*NREQ-1:0] req_wdata_i,
   output logic [NREQ-1:0]   rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              eng_start_o,
   output logic              eng_we_o,
   output logic [31:0]       eng_addr_o,
   output logic [31:0]       eng_wdata_o,
   input  logic              eng_done_i,
   input  logic              eng_nack_i,
   input  logic [31:0]       eng_rdata_i,
   output logic              busy_o
);

   localparam int               IDX_W    = $clog2(NREQ);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d;
   logic             we_q, we_d, err_q, err_d;
   logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [TMO_W-1:0] timer_q, timer_d;

   logic [NREQ-1:0]  pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   i2c_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req_i    (req_valid_i),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_oh),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   // State and latched operand registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         timer_q  <= timer_d;
      end
   end

   // Next-state logic; a done pulse arriving outside WAIT falls through untouched.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      timer_d  = timer_q;
      case (state_q)
         S_IDLE: if (pick_any) begin
            id_d    = pick_idx;
            we_d    = req_we_i[pick_idx];
            addr_d  = req_addr_i[32*int'(pick_idx) +: 32];
            wdata_d = req_wdata_i[32*int'(pick_idx) +: 32];
            state_d = S_START;
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (timer_q != {TMO_W{1'b1}}) timer_d = timer_q + TMO_W'(1);
            if (eng_done_i) begin
               rdata_d = we_q ? 32'h0 : eng_rdata_i;
               err_d   = eng_nack_i;
               state_d = S_RESP;
            end else if (timer_q == TMO_LAST) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            rr_ptr_d = (id_q == IDX_W'(NREQ - 1)) ? '0 : id_q + IDX_W'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and completion strobes decoded from state.
   always_comb begin
      req_ready_o = (state_q == S_IDLE) ? pick_oh : '0;
      rsp_valid_o = '0;
      if (state_q == S_RESP) rsp_valid_o[id_q] = 1'b1;
   end

   assign eng_start_o = (state_q == S_START);
   assign busy_o      = (state_q != S_IDLE);
   assign eng_we_o    = we_q;
   assign eng_addr_o  = addr_q;
   assign eng_wdata_o = wdata_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_i2c_ahb_txn_arbiter.sv
// Randomized bench for i2c_ahb_txn_arbiter with a transaction-level reference model.
module tb_i2c_ahb_txn_arbiter;

   localparam int NREQ = 2;
   localparam int TMO  = 16;

   logic        clk, rst_n;
   logic [1:0]  req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
   logic [63:0] req_addr_i, req_wdata_i;
   logic [31:0] rsp_rdata_o, eng_addr_o, eng_wdata_o, eng_rdata_i;
   logic        rsp_err_o, eng_start_o, eng_we_o, eng_done_i, eng_nack_i, busy_o;

   int checks = 0;
   int failures = 0;
   int m_ptr = 0;   // model round-robin pointer

   i2c_ahb_txn_arbiter #(.NREQ(NREQ), .TMO_W(20), .TMO_CYC(TMO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .eng_start_o(eng_start_o), .eng_we_o(eng_we_o), .eng_addr_o(eng_addr_o),
      .eng_wdata_o(eng_wdata_o), .eng_done_i(eng_done_i), .eng_nack_i(eng_nack_i),
      .eng_rdata_i(eng_rdata_i), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   // Drive one transaction end to end; expectations come from arbitration rules in the model.
   task automatic run_txn(input logic [1:0] vm, input logic [1:0] wm, input logic [63:0] ad,
                          input logic [63:0] wd, input int lat, input bit nack, input logic [31:0] erd);
      int win; bit to; logic [1:0] oh; logic [31:0] e_rd, e_ad, e_wd; logic e_err, e_we;
      win = -1;
      for (int i = 0; i < NREQ; i++)
         if (win < 0 && vm[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
      oh    = 2'b01 << win;
      to    = (lat >= TMO);
      e_err = to ? 1'b1 : nack;
      e_we  = wm[win];
      e_rd  = (to || e_we) ? 32'h0 : erd;
      e_ad  = ad[32*win +: 32];
      e_wd  = wd[32*win +: 32];
      req_valid_i = vm; req_we_i = wm; req_addr_i = ad; req_wdata_i = wd; #1;
      checks++; if (req_ready_o !== oh) begin failures++; $display("FAIL ready got=%b exp=%b", req_ready_o, oh); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy_o); end
      step();
      req_valid_i = '0; req_we_i = ~wm; req_addr_i = {$urandom, $urandom}; req_wdata_i = {$urandom, $urandom}; #1;
      checks++; if (eng_start_o !== 1'b1) begin failures++; $display("FAIL start got=%b exp=1", eng_start_o); end
      checks++; if (eng_we_o !== e_we) begin failures++; $display("FAIL eng_we got=%b exp=%b", eng_we_o, e_we); end
      checks++; if (eng_addr_o !== e_ad) begin failures++; $display("FAIL eng_addr got=%h exp=%h", eng_addr_o, e_ad); end
      checks++; if (eng_wdata_o !== e_wd) begin failures++; $display("FAIL eng_wdata got=%h exp=%h", eng_wdata_o, e_wd); end
      checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL ready_busy got=%b exp=00", req_ready_o); end
      step();
      for (int w = 0; w < TMO; w++) begin
         eng_done_i = (w == lat); eng_nack_i = nack; eng_rdata_i = erd; #1;
         checks++; if (eng_start_o !== 1'b0 || rsp_valid_o !== 2'b00 || eng_addr_o !== e_ad)
            begin failures++; $display("FAIL wait w=%0d start=%b rsp=%b addr=%h exp_addr=%h", w, eng_start_o, rsp_valid_o, eng_addr_o, e_ad); end
         step();
         eng_done_i = 1'b0; eng_nack_i = 1'b0; eng_rdata_i = $urandom;
         if (w == lat) break;
      end
      #1;
      checks++; if (rsp_valid_o !== oh) begin failures++; $display("FAIL rsp_valid got=%b exp=%b", rsp_valid_o, oh); end
      checks++; if (rsp_rdata_o !== e_rd) begin failures++; $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata_o, e_rd); end
      checks++; if (rsp_err_o !== e_err) begin failures++; $display("FAIL rsp_err got=%b exp=%b", rsp_err_o, e_err); end
      step(); #1;
      checks++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin failures++; $display("FAIL post_rsp rsp=%b busy=%b exp 00/0", rsp_valid_o, busy_o); end
      checks++; if (rsp_rdata_o !== e_rd || rsp_err_o !== e_err) begin failures++; $display("FAIL rsp_hold rdata=%h err=%b exp %h/%b", rsp_rdata_o, rsp_err_o, e_rd, e_err); end
      m_ptr = (win == NREQ - 1) ? 0 : win + 1;
   endtask

   // Every output must read zero while reset is held.
   task automatic check_zero(input string tag);
      checks++;
      if (busy_o !== 1'b0 || eng_start_o !== 1'b0 || eng_we_o !== 1'b0 || eng_addr_o !== 32'h0 ||
          eng_wdata_o !== 32'h0 || rsp_valid_o !== 2'b00 || rsp_rdata_o !== 32'h0 ||
          rsp_err_o !== 1'b0 || req_ready_o !== 2'b00) begin
         failures++;
         $display("FAIL %s busy=%b start=%b we=%b addr=%h wdata=%h rsp=%b rdata=%h err=%b ready=%b exp all 0",
                  tag, busy_o, eng_start_o, eng_we_o, eng_addr_o, eng_wdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
      end
   endtask

   task automatic test_reset();
      #1; check_zero("reset_state");
      rst_n = 1'b1; m_ptr = 0;
      step();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (req_ready_o !== 2'b00 || busy_o !== 1'b0) begin failures++; $display("FAIL idle ready=%b busy=%b exp 00/0", req_ready_o, busy_o); end
         step();
      end
   endtask

   task automatic test_write();
      run_txn(2'b01, 2'b01, {32'h0, 32'h1000_0004}, {32'h0, 32'hDEAD_BEEF}, 10, 1'b0, 32'hFFFF_FFFF);
   endtask

   task automatic test_read();
      run_txn(2'b10, 2'b00, {32'h2000_0000, 32'h0}, 64'h0, 5, 1'b0, 32'h1234_5678);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         run_txn(2'b11, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, i, 1'b0, $urandom);
   endtask

   task automatic test_timeout();
      run_txn(2'b01, 2'b00, {32'h0, 32'h3000_0010}, 64'h0, 40, 1'b0, 32'hCAFE_0001);
      eng_done_i = 1'b1; eng_rdata_i = 32'h5555_AAAA; step(); eng_done_i = 1'b0; #1;
      checks++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0)
         begin failures++; $display("FAIL late_done rsp=%b busy=%b err=%b rdata=%h exp 00/0/1/0", rsp_valid_o, busy_o, rsp_err_o, rsp_rdata_o); end
      step();
   endtask

   task automatic test_nack();
      run_txn(2'b01, 2'b00, {32'h0, 32'h4000_0000}, 64'h0, 3, 1'b1, 32'h0BAD_F00D);
      run_txn(2'b11, 2'b00, {32'h4000_0008, 32'h4000_0004}, 64'h0, 2, 1'b0, 32'h0000_0042);
   endtask

   task automatic test_reset_mid();
      run_txn(2'b01, 2'b00, {32'h0, 32'h5000_0000}, 64'h0, 3, 1'b0, 32'hA5A5_0001);
      req_valid_i = 2'b10; req_we_i = 2'b10; req_addr_i = {32'h6000_00F0, 32'h0}; req_wdata_i = {32'h1111_2222, 32'h0};
      step(); req_valid_i = 2'b00; step(); step();
      rst_n = 1'b0; #1;
      check_zero("reset_mid");
      step(); rst_n = 1'b1; m_ptr = 0;
      run_txn(2'b11, 2'b11, {32'h7000_0004, 32'h7000_0000}, {32'h2, 32'h1}, 4, 1'b0, 32'h0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [1:0] vm;
         vm = 2'($urandom_range(1, 3));
         run_txn(vm, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 int'($urandom_range(0, 20)), 1'($urandom), $urandom);
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0;
      eng_done_i = 1'b0; eng_nack_i = 1'b0; eng_rdata_i = '0;
      repeat (3) @(posedge clk); #2;
      test_reset();
      test_idle();
      test_write();
      test_read();
      test_back_to_back();
      test_timeout();
      test_nack();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
